phy_rx_deser: RTL and testbench

//  Receive side of the two-lane PHY. Converts each lane's serial bit stream (MSB first) into 8-bit

---
 rtl/phy_rx_deser_pkg.sv | 13 +
 rtl/phy_rx_deser_lane_align.sv | 88 ++++++++
 rtl/phy_rx_deser.sv | 48 ++++
 tb/tb_phy_rx_deser.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_rx_deser_pkg.sv
// Shared definitions for the PHY receive deserializer: the COM character
// and the per-lane alignment state encoding.
package phy_rx_deser_pkg;

    localparam logic [7:0] COM_CHAR = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } lane_state_t;

endpackage : phy_rx_deser_pkg

// File: rtl/phy_rx_deser_lane_align.sv
// One receive lane: shifts the serial stream MSB first, locks onto the COM
// character and then emits one byte every 8 bit times.
module rx_lane_align
    import phy_rx_deser_pkg::*;
#(
    parameter logic [7:0]  COM      = COM_CHAR,
    parameter int unsigned BC_COUNT = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_stb,
    output logic       active
);

    localparam logic [3:0] BC_LIM = 4'(BC_COUNT);

    lane_state_t state;
    logic [7:0]  sr;
    logic [2:0]  bit_cnt;
    logic [3:0]  bc_cnt;
    logic [3:0]  bc_next;
    logic        sr_is_com;
    logic        at_boundary;

    // Saturating COM counter and boundary decode
    always_comb begin
        bc_next     = (bc_cnt >= BC_LIM) ? bc_cnt : bc_cnt + 4'd1;
        sr_is_com   = (sr == COM);
        at_boundary = (bit_cnt == 3'd7);
    end

    // Shift register, bit counter, alignment FSM and registered outputs
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state     <= SEARCH;
            sr        <= '0;
            bit_cnt   <= '0;
            bc_cnt    <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            byte_stb  <= 1'b0;
            active    <= 1'b0;
        end else begin
            sr       <= {sr[6:0], serial_in};
            bit_cnt  <= bit_cnt + 3'd1;
            byte_stb <= 1'b0;
            case (state)
                SEARCH: begin
                    // Restarting the counter here puts the next boundary
                    // exactly one byte after the COM just seen.
                    if (sr_is_com) begin
                        bit_cnt <= '0;
                        bc_cnt  <= 4'd1;
                        state   <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (at_boundary) begin
                        if (sr_is_com) begin
                            bc_cnt <= bc_next;
                            if (bc_next >= BC_LIM) begin
                                state  <= ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            bc_cnt <= '0;
                            state  <= SEARCH;
                        end
                    end
                end
                ACTIVE: begin
                    if (at_boundary) begin
                        data_out  <= sr;
                        valid_out <= !sr_is_com;
                        byte_stb  <= 1'b1;
                    end
                end
                default: begin
                    state <= SEARCH;
                end
            endcase
        end
    end

endmodule : rx_lane_align

// File: rtl/phy_rx_deser.sv
// Two-lane PHY receive deserializer; each lane is an independent aligner.
module phy_rx_deser
    import phy_rx_deser_pkg::*;
#(
    parameter logic [7:0]  COM      = COM_CHAR,
    parameter int unsigned BC_COUNT = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       serial_in_0,
    input  logic       serial_in_1,
    output logic [7:0] data_out_0,
    output logic [7:0] data_out_1,
    output logic       valid_out_0,
    output logic       valid_out_1,
    output logic       byte_stb_0,
    output logic       byte_stb_1,
    output logic       active_0,
    output logic       active_1
);

    rx_lane_align #(
        .COM      (COM),
        .BC_COUNT (BC_COUNT)
    ) u_lane_0 (
        .clk_8f    (clk_8f),
        .reset     (reset),
        .serial_in (serial_in_0),
        .data_out  (data_out_0),
        .valid_out (valid_out_0),
        .byte_stb  (byte_stb_0),
        .active    (active_0)
    );

    rx_lane_align #(
        .COM      (COM),
        .BC_COUNT (BC_COUNT)
    ) u_lane_1 (
        .clk_8f    (clk_8f),
        .reset     (reset),
        .serial_in (serial_in_1),
        .data_out  (data_out_1),
        .valid_out (valid_out_1),
        .byte_stb  (byte_stb_1),
        .active    (active_1)
    );

endmodule : phy_rx_deser

// File: tb/tb_phy_rx_deser.sv
// Directed bench for phy_rx_deser: lock, data, COM suppression, phase
// offset, lane independence and mid-operation reset.
module tb_phy_rx_deser;

    logic       clk_8f;
    logic       reset;
    logic       serial_in_0;
    logic       serial_in_1;
    logic [7:0] data_out_0;
    logic [7:0] data_out_1;
    logic       valid_out_0;
    logic       valid_out_1;
    logic       byte_stb_0;
    logic       byte_stb_1;
    logic       active_0;
    logic       active_1;

    int vectors;
    int miscompares;

    // per-run capture
    logic       q0[$];
    logic       q1[$];
    int         cyc0[$];
    int         cyc1[$];
    logic [7:0] dat0[$];
    logic [7:0] dat1[$];
    logic       val0[$];
    logic       val1[$];
    int         rise0;
    int         rise1;
    int         drop0;
    int         hold_err0;

    phy_rx_deser #(
        .COM      (8'hBC),
        .BC_COUNT (4)
    ) dut (
        .clk_8f      (clk_8f),
        .reset       (reset),
        .serial_in_0 (serial_in_0),
        .serial_in_1 (serial_in_1),
        .data_out_0  (data_out_0),
        .data_out_1  (data_out_1),
        .valid_out_0 (valid_out_0),
        .valid_out_1 (valid_out_1),
        .byte_stb_0  (byte_stb_0),
        .byte_stb_1  (byte_stb_1),
        .active_0    (active_0),
        .active_1    (active_1)
    );

    initial begin
        clk_8f = 1'b0;
        forever #5 clk_8f = ~clk_8f;
    end

    task automatic push_byte(input int lane, input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            if (lane == 0) q0.push_back(b[i]);
            else           q1.push_back(b[i]);
        end
    endtask

    task automatic push_bits(input int lane, input logic [7:0] b, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            if (lane == 0) q0.push_back(b[i]);
            else           q1.push_back(b[i]);
        end
    endtask

    task automatic clear_recs();
        q0.delete(); q1.delete();
        cyc0.delete(); cyc1.delete();
        dat0.delete(); dat1.delete();
        val0.delete(); val1.delete();
        rise0 = -1; rise1 = -1;
        drop0 = 0; hold_err0 = 0;
    endtask

    // reset for 2 cycles; the next posedge after return is edge 0 of a run
    task automatic do_reset();
        reset = 1'b1;
        serial_in_0 = 1'b0;
        serial_in_1 = 1'b0;
        repeat (2) @(posedge clk_8f);
        #1;
        reset = 1'b0;
        clear_recs();
    endtask

    // shift both queues out for n edges, logging outputs 1 time unit after each edge
    task automatic run(input int n);
        logic       pa0, pa1;
        logic [7:0] pd0;
        pa0 = active_0; pa1 = active_1; pd0 = data_out_0;
        for (int i = 0; i < n; i++) begin
            serial_in_0 = (q0.size() > 0) ? q0.pop_front() : 1'b0;
            serial_in_1 = (q1.size() > 0) ? q1.pop_front() : 1'b0;
            @(posedge clk_8f);
            #1;
            if (byte_stb_0) begin
                cyc0.push_back(i); dat0.push_back(data_out_0); val0.push_back(valid_out_0);
            end else if (data_out_0 !== pd0) begin
                hold_err0++;
            end
            if (byte_stb_1) begin
                cyc1.push_back(i); dat1.push_back(data_out_1); val1.push_back(valid_out_1);
            end
            if (active_0 && !pa0 && rise0 < 0) rise0 = i;
            if (active_1 && !pa1 && rise1 < 0) rise1 = i;
            if (!active_0 && pa0) drop0++;
            pa0 = active_0; pa1 = active_1; pd0 = data_out_0;
        end
    endtask

    task automatic test_reset();
        logic [11:0] outs;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serial_in_0 = 1'($urandom_range(1, 0));
            serial_in_1 = 1'($urandom_range(1, 0));
            @(posedge clk_8f);
            #1;
            outs = {valid_out_0, valid_out_1, byte_stb_0, byte_stb_1, active_0, active_1,
                    data_out_0[2:0], data_out_1[2:0]};
            vectors++;
            if ({data_out_0, data_out_1, outs} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs cycle %0d: got d0=%h d1=%h flags=%b, want all 0",
                         i, data_out_0, data_out_1, outs);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_lock_and_data();
        do_reset();
        repeat (4) push_byte(0, 8'hBC);
        push_byte(0, 8'hDD);
        push_byte(0, 8'hEC);
        run(52);
        vectors++;
        if (rise0 !== 32) begin
            miscompares++;
            $display("FAIL lock_rise got %0d want 32", rise0);
        end
        vectors++;
        if (cyc0.size() !== 2) begin
            miscompares++;
            $display("FAIL lock_stb_count got %0d want 2", cyc0.size());
        end else begin
            vectors++;
            if ({cyc0[0], dat0[0], val0[0]} !== {32'sd40, 8'hDD, 1'b1}) begin
                miscompares++;
                $display("FAIL lock_byte0 got cyc=%0d d=%h v=%b want cyc=40 d=DD v=1",
                         cyc0[0], dat0[0], val0[0]);
            end
            vectors++;
            if ({cyc0[1], dat0[1], val0[1]} !== {32'sd48, 8'hEC, 1'b1}) begin
                miscompares++;
                $display("FAIL lock_byte1 got cyc=%0d d=%h v=%b want cyc=48 d=EC v=1",
                         cyc0[1], dat0[1], val0[1]);
            end
        end
        vectors++;
        if (rise1 !== -1 || cyc1.size() !== 0) begin
            miscompares++;
            $display("FAIL idle_lane1 got rise=%0d stbs=%0d want -1/0", rise1, cyc1.size());
        end
    endtask

    task automatic test_broken_lock();
        do_reset();
        repeat (3) push_byte(0, 8'hBC);
        push_byte(0, 8'hDD);
        repeat (4) push_byte(0, 8'hBC);
        push_byte(0, 8'h0C);
        run(76);
        vectors++;
        if (rise0 !== 64) begin
            miscompares++;
            $display("FAIL relock_rise got %0d want 64", rise0);
        end
        vectors++;
        if (cyc0.size() !== 1) begin
            miscompares++;
            $display("FAIL relock_stb_count got %0d want 1", cyc0.size());
        end else begin
            vectors++;
            if ({cyc0[0], dat0[0], val0[0]} !== {32'sd72, 8'h0C, 1'b1}) begin
                miscompares++;
                $display("FAIL relock_byte got cyc=%0d d=%h v=%b want cyc=72 d=0C v=1",
                         cyc0[0], dat0[0], val0[0]);
            end
        end
    endtask

    task automatic test_com_in_active();
        do_reset();
        repeat (5) push_byte(0, 8'hBC);
        push_byte(0, 8'hAA);
        run(60);
        vectors++;
        if (cyc0.size() < 2) begin
            miscompares++;
            $display("FAIL com_stb_count got %0d want >=2", cyc0.size());
        end else begin
            vectors++;
            if ({cyc0[0], dat0[0], val0[0]} !== {32'sd40, 8'hBC, 1'b0}) begin
                miscompares++;
                $display("FAIL com_byte got cyc=%0d d=%h v=%b want cyc=40 d=BC v=0",
                         cyc0[0], dat0[0], val0[0]);
            end
            vectors++;
            if ({dat0[1], val0[1]} !== {8'hAA, 1'b1}) begin
                miscompares++;
                $display("FAIL com_next_byte got d=%h v=%b want d=AA v=1", dat0[1], val0[1]);
            end
            vectors++;
            if (cyc0[1] - cyc0[0] !== 8) begin
                miscompares++;
                $display("FAIL stb_spacing got %0d want 8", cyc0[1] - cyc0[0]);
            end
        end
        vectors++;
        if (hold_err0 !== 0) begin
            miscompares++;
            $display("FAIL data_hold got %0d changes without strobe want 0", hold_err0);
        end
    endtask

    task automatic test_phase_and_lanes();
        do_reset();
        push_bits(0, 8'b010, 3);
        repeat (4) push_byte(0, 8'hBC);
        push_byte(0, 8'h99);
        push_bits(1, 8'b01101, 5);
        repeat (4) push_byte(1, 8'hBC);
        push_byte(1, 8'h3C);
        run(48);
        vectors++;
        if (rise0 !== 35 || rise1 !== 37) begin
            miscompares++;
            $display("FAIL phase_rise got %0d/%0d want 35/37", rise0, rise1);
        end
        vectors++;
        if (cyc0.size() !== 1 || cyc1.size() !== 1) begin
            miscompares++;
            $display("FAIL phase_stb_count got %0d/%0d want 1/1", cyc0.size(), cyc1.size());
        end else begin
            vectors++;
            if ({cyc0[0], dat0[0], val0[0]} !== {32'sd43, 8'h99, 1'b1}) begin
                miscompares++;
                $display("FAIL phase_lane0 got cyc=%0d d=%h v=%b want cyc=43 d=99 v=1",
                         cyc0[0], dat0[0], val0[0]);
            end
            vectors++;
            if ({cyc1[0], dat1[0], val1[0]} !== {32'sd45, 8'h3C, 1'b1}) begin
                miscompares++;
                $display("FAIL phase_lane1 got cyc=%0d d=%h v=%b want cyc=45 d=3C v=1",
                         cyc1[0], dat1[0], val1[0]);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        repeat (4) push_byte(0, 8'hBC);
        push_byte(0, 8'h5A);
        run(41);
        vectors++;
        if ({active_0, data_out_0, valid_out_0} !== {1'b1, 8'h5A, 1'b1}) begin
            miscompares++;
            $display("FAIL pre_reset got act=%b d=%h v=%b want 1/5A/1",
                     active_0, data_out_0, valid_out_0);
        end
        reset = 1'b1;
        serial_in_0 = 1'b1;
        @(posedge clk_8f);
        #1;
        vectors++;
        if ({active_0, data_out_0, valid_out_0, byte_stb_0} !== 11'd0) begin
            miscompares++;
            $display("FAIL mid_reset got act=%b d=%h v=%b s=%b want all 0",
                     active_0, data_out_0, valid_out_0, byte_stb_0);
        end
        reset = 1'b0;
        clear_recs();
        push_byte(0, 8'h11);
        push_byte(0, 8'h22);
        repeat (4) push_byte(0, 8'hBC);
        push_byte(0, 8'h77);
        run(60);
        vectors++;
        if (rise0 !== 48 || drop0 !== 0) begin
            miscompares++;
            $display("FAIL post_reset_rise got %0d drops=%0d want 48/0", rise0, drop0);
        end
        vectors++;
        if (cyc0.size() !== 1) begin
            miscompares++;
            $display("FAIL post_reset_stb_count got %0d want 1", cyc0.size());
        end else begin
            vectors++;
            if ({cyc0[0], dat0[0], val0[0]} !== {32'sd56, 8'h77, 1'b1}) begin
                miscompares++;
                $display("FAIL post_reset_byte got cyc=%0d d=%h v=%b want cyc=56 d=77 v=1",
                         cyc0[0], dat0[0], val0[0]);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        serial_in_0 = 1'b0;
        serial_in_1 = 1'b0;
        clear_recs();
        test_reset();
        test_lock_and_data();
        test_broken_lock();
        test_com_in_active();
        test_phase_and_lanes();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_phy_rx_deser
